// File: rtl/scr1_arb_pkg.sv
// Shared types and defaults for the imem/dmem memory arbiter.
// Memif command, width and response encodings are carried here so every file sees one definition.
package scr1_arb_pkg;

  localparam int SCR1_IMEM_AWIDTH = 32;
  localparam int SCR1_IMEM_DWIDTH = 32;
  localparam int SCR1_DMEM_AWIDTH = 32;
  localparam int SCR1_DMEM_DWIDTH = 32;

  localparam int SCR1_ARB_OUTST_DEPTH_DFLT  = 2;
  localparam int SCR1_ARB_STARVE_LIMIT_DFLT = 4;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  typedef enum logic {
    SCR1_ARB_PORT_IMEM = 1'b0,
    SCR1_ARB_PORT_DMEM = 1'b1
  } type_scr1_arb_port_e;

endpackage

// File: rtl/scr1_arb_id_fifo.sv
// In-order FIFO of 1-bit owner IDs for requests that were acked but not yet answered.
// Full is taken from the registered count only, so a pop never frees a slot in the same cycle.
module scr1_arb_id_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head_id
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (DEPTH == 1) return '0;
    return ptr + 1'b1;
  endfunction

  assign full    = (cnt_q == CNT_MAX);
  assign empty   = (cnt_q == '0);
  assign head_id = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_id;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/scr1_mem_arbiter.sv
// Two-to-one memif arbiter: imem and dmem share one pipelined downstream port.
// Dmem wins ties until LIMIT dmem grants pass with imem waiting; responses follow the ID FIFO.
module scr1_mem_arbiter
  import scr1_arb_pkg::*;
#(
  parameter int SCR1_ARB_OUTST_DEPTH  = SCR1_ARB_OUTST_DEPTH_DFLT,
  parameter int SCR1_ARB_STARVE_LIMIT = SCR1_ARB_STARVE_LIMIT_DFLT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        imem_req,
  input  type_scr1_mem_cmd_e          imem_cmd,
  input  logic [SCR1_IMEM_AWIDTH-1:0] imem_addr,
  output logic                        imem_req_ack,
  output logic [SCR1_IMEM_DWIDTH-1:0] imem_rdata,
  output type_scr1_mem_resp_e         imem_resp,
  input  logic                        dmem_req,
  input  type_scr1_mem_cmd_e          dmem_cmd,
  input  type_scr1_mem_width_e        dmem_width,
  input  logic [SCR1_DMEM_AWIDTH-1:0] dmem_addr,
  input  logic [SCR1_DMEM_DWIDTH-1:0] dmem_wdata,
  output logic                        dmem_req_ack,
  output logic [SCR1_DMEM_DWIDTH-1:0] dmem_rdata,
  output type_scr1_mem_resp_e         dmem_resp,
  output logic                        mem_req,
  output type_scr1_mem_cmd_e          mem_cmd,
  output type_scr1_mem_width_e        mem_width,
  output logic [SCR1_DMEM_AWIDTH-1:0] mem_addr,
  output logic [SCR1_DMEM_DWIDTH-1:0] mem_wdata,
  input  logic                        mem_req_ack,
  input  logic [SCR1_DMEM_DWIDTH-1:0] mem_rdata,
  input  type_scr1_mem_resp_e         mem_resp
);

  localparam int STARVE_W = $clog2(SCR1_ARB_STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(SCR1_ARB_STARVE_LIMIT);

  type_scr1_arb_port_e grant, lock_port_q, lock_port_d, fifo_head;
  logic                lock_q, lock_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                fifo_full, fifo_empty, fifo_head_bit;
  logic                req_sel, acc, imem_acc, dmem_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q      <= 1'b0;
      lock_port_q <= SCR1_ARB_PORT_DMEM;
      starve_q    <= '0;
    end else begin
      lock_q      <= lock_d;
      lock_port_q <= lock_port_d;
      starve_q    <= starve_d;
    end
  end

  // A request shown but not accepted pins the grant until the ack arrives.
  always_comb begin
    lock_d      = mem_req & ~mem_req_ack;
    lock_port_d = grant;
    starve_d    = starve_q;
    if (imem_acc | ~imem_req) begin
      starve_d = '0;
    end else if (dmem_acc & (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_comb begin
    if (lock_q) begin
      grant = lock_port_q;
    end else if (imem_req & dmem_req) begin
      grant = (starve_q == STARVE_MAX) ? SCR1_ARB_PORT_IMEM : SCR1_ARB_PORT_DMEM;
    end else if (imem_req) begin
      grant = SCR1_ARB_PORT_IMEM;
    end else begin
      grant = SCR1_ARB_PORT_DMEM;
    end
    req_sel      = (grant == SCR1_ARB_PORT_IMEM) ? imem_req : dmem_req;
    mem_req      = ~fifo_full & req_sel;
    acc          = mem_req & mem_req_ack;
    imem_acc     = acc & (grant == SCR1_ARB_PORT_IMEM);
    dmem_acc     = acc & (grant == SCR1_ARB_PORT_DMEM);
    imem_req_ack = imem_acc;
    dmem_req_ack = dmem_acc;
    if (grant == SCR1_ARB_PORT_IMEM) begin
      mem_cmd   = imem_cmd;
      mem_width = SCR1_MEM_WIDTH_WORD;
      mem_addr  = SCR1_DMEM_AWIDTH'(imem_addr);
      mem_wdata = '0;
    end else begin
      mem_cmd   = dmem_cmd;
      mem_width = dmem_width;
      mem_addr  = dmem_addr;
      mem_wdata = dmem_wdata;
    end
  end

  scr1_arb_id_fifo #(
    .DEPTH (SCR1_ARB_OUTST_DEPTH)
  ) i_id_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (acc),
    .push_id (grant == SCR1_ARB_PORT_DMEM),
    .pop     (mem_resp != SCR1_MEM_RESP_NOTRDY),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head_id (fifo_head_bit)
  );

  assign fifo_head = type_scr1_arb_port_e'(fifo_head_bit);

  // With nothing outstanding the downstream response is dropped.
  always_comb begin
    imem_resp  = SCR1_MEM_RESP_NOTRDY;
    imem_rdata = '0;
    dmem_resp  = SCR1_MEM_RESP_NOTRDY;
    dmem_rdata = '0;
    if (!fifo_empty) begin
      if (fifo_head == SCR1_ARB_PORT_IMEM) begin
        imem_resp  = mem_resp;
        imem_rdata = mem_rdata[SCR1_IMEM_DWIDTH-1:0];
      end else begin
        dmem_resp  = mem_resp;
        dmem_rdata = mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_scr1_mem_arbiter.sv
// Randomized bench for scr1_mem_arbiter: requester and downstream models drive the DUT,
// a transaction-level model predicts acks, and a scoreboard checks responses as they return.
module tb_scr1_mem_arbiter;
  import scr1_arb_pkg::*;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 imem_req = 1'b0;
  type_scr1_mem_cmd_e   imem_cmd = SCR1_MEM_CMD_RD;
  logic [31:0]          imem_addr = '0;
  logic                 imem_req_ack;
  logic [31:0]          imem_rdata;
  type_scr1_mem_resp_e  imem_resp;
  logic                 dmem_req = 1'b0;
  type_scr1_mem_cmd_e   dmem_cmd = SCR1_MEM_CMD_RD;
  type_scr1_mem_width_e dmem_width = SCR1_MEM_WIDTH_WORD;
  logic [31:0]          dmem_addr = '0;
  logic [31:0]          dmem_wdata = '0;
  logic                 dmem_req_ack;
  logic [31:0]          dmem_rdata;
  type_scr1_mem_resp_e  dmem_resp;
  logic                 mem_req;
  type_scr1_mem_cmd_e   mem_cmd;
  type_scr1_mem_width_e mem_width;
  logic [31:0]          mem_addr;
  logic [31:0]          mem_wdata;
  logic                 mem_req_ack = 1'b0;
  logic [31:0]          mem_rdata = '0;
  type_scr1_mem_resp_e  mem_resp = SCR1_MEM_RESP_NOTRDY;

  scr1_mem_arbiter #(
    .SCR1_ARB_OUTST_DEPTH  (DEPTH),
    .SCR1_ARB_STARVE_LIMIT (LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_cmd(imem_cmd), .imem_addr(imem_addr),
    .imem_req_ack(imem_req_ack), .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_cmd(dmem_cmd), .dmem_width(dmem_width),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_req_ack(dmem_req_ack), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .mem_req(mem_req), .mem_cmd(mem_cmd), .mem_width(mem_width),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_req_ack(mem_req_ack), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  typedef struct { bit port; type_scr1_mem_resp_e resp; logic [31:0] data; } exp_t;
  typedef struct { int due; type_scr1_mem_resp_e resp; logic [31:0] data; } pend_t;
  exp_t  exp_q[$];
  pend_t pend_q[$];

  // Requester transactions (port 0 = imem, 1 = dmem) and the reference model state.
  bit                   iv, dv;
  logic [31:0]          iaddr, daddr, dwdata;
  type_scr1_mem_cmd_e   dcmd;
  type_scr1_mem_width_e dwidth;
  int  cyc = 0, ost = 0, starve = 0, last_due = 0;
  bit  lock_v = 0, lock_p = 0;
  int  req_pct = 0, ack_pct = 100, dmin = 1, dmax = 1, err_pct = 0;
  bit  inject_late = 0, use_next = 0, log_en = 0;
  logic [31:0] next_data;
  string glog = "";

  task automatic step();
    pend_t p;
    bit resp_drv, full, g, rq, emr, ea, ireq;
    type_scr1_mem_resp_e r;
    logic [31:0] d;
    int due;
    @(posedge clk);
    cyc++;
    #1;
    if (!iv && $urandom_range(99) < req_pct) begin
      iv = 1; iaddr = $urandom & 32'hFFFF_FFFC;
    end
    if (!dv && $urandom_range(99) < req_pct) begin
      dv = 1; daddr = $urandom; dwdata = $urandom;
      dcmd = type_scr1_mem_cmd_e'($urandom_range(1));
      dwidth = type_scr1_mem_width_e'($urandom_range(2));
    end
    imem_req = iv; imem_addr = iaddr; imem_cmd = SCR1_MEM_CMD_RD;
    dmem_req = dv; dmem_addr = daddr; dmem_wdata = dwdata;
    dmem_cmd = dcmd; dmem_width = dwidth;
    mem_req_ack = ($urandom_range(99) < ack_pct);
    resp_drv = 0;
    if (inject_late) begin
      mem_resp = SCR1_MEM_RESP_RDY_OK; mem_rdata = 32'hDEAD_BEEF; inject_late = 0;
    end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      p = pend_q.pop_front();
      mem_resp = p.resp; mem_rdata = p.data; resp_drv = 1;
    end else begin
      mem_resp = SCR1_MEM_RESP_NOTRDY; mem_rdata = $urandom;
    end
    @(negedge clk);
    ireq = iv;
    full = (ost == DEPTH);
    if (lock_v) g = lock_p;
    else if (iv && dv) g = (starve == LIMIT) ? 1'b0 : 1'b1;
    else g = iv ? 1'b0 : 1'b1;
    rq  = g ? dv : iv;
    emr = !full && rq;
    ea  = emr && mem_req_ack;
    chk("mem_req", mem_req, emr);
    chk("imem_req_ack", imem_req_ack, ea && !g);
    chk("dmem_req_ack", dmem_req_ack, ea && g);
    if (emr) begin
      chk("mem_addr", mem_addr, g ? daddr : iaddr);
      chk("mem_cmd", mem_cmd, g ? dcmd : SCR1_MEM_CMD_RD);
      chk("mem_width", mem_width, g ? dwidth : SCR1_MEM_WIDTH_WORD);
      chk("mem_wdata", mem_wdata, g ? dwdata : 32'h0);
    end
    if (ea) begin
      r = ($urandom_range(99) < err_pct) ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
      d = use_next ? next_data : $urandom;
      use_next = 0;
      exp_q.push_back('{g, r, d});
      due = cyc + dmin + $urandom_range(dmax - dmin);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend_q.push_back('{due, r, d});
      ost++;
      if (g) dv = 0; else iv = 0;
      if (log_en && glog.len() < 10) glog = {glog, g ? "D" : "I"};
    end
    if (resp_drv) ost--;
    if ((ea && !g) || !ireq) starve = 0;
    else if (ea && g && starve < LIMIT) starve++;
    lock_v = emr && !mem_req_ack;
    lock_p = g;
  endtask

  task automatic drain();
    int n = 0;
    req_pct = 0; ack_pct = 100;
    while ((iv || dv || pend_q.size() > 0 || exp_q.size() > 0) && n < 200) begin
      step(); n++;
    end
    total++;
    if (n >= 200) begin
      bad++;
      $display("FAIL drain_timeout: outstanding=%0d expected=0", exp_q.size());
    end
  endtask

  // Scoreboard: each downstream response must reach the owner recorded at ack time.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (mem_resp != SCR1_MEM_RESP_NOTRDY || imem_resp != SCR1_MEM_RESP_NOTRDY ||
                  dmem_resp != SCR1_MEM_RESP_NOTRDY)) begin
      if (exp_q.size() == 0) begin
        chk("orphan_imem_resp", imem_resp, SCR1_MEM_RESP_NOTRDY);
        chk("orphan_dmem_resp", dmem_resp, SCR1_MEM_RESP_NOTRDY);
        chk("orphan_imem_rdata", imem_rdata, 32'h0);
        chk("orphan_dmem_rdata", dmem_rdata, 32'h0);
      end else begin
        e = exp_q.pop_front();
        if (e.port) begin
          chk("dmem_resp", dmem_resp, e.resp);
          chk("dmem_rdata", dmem_rdata, e.data);
          chk("imem_resp_idle", imem_resp, SCR1_MEM_RESP_NOTRDY);
          chk("imem_rdata_idle", imem_rdata, 32'h0);
        end else begin
          chk("imem_resp", imem_resp, e.resp);
          chk("imem_rdata", imem_rdata, e.data);
          chk("dmem_resp_idle", dmem_resp, SCR1_MEM_RESP_NOTRDY);
          chk("dmem_rdata_idle", dmem_rdata, 32'h0);
        end
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_imem_ack"}, imem_req_ack, 1'b0);
    chk({tag, "_dmem_ack"}, dmem_req_ack, 1'b0);
    chk({tag, "_imem_resp"}, imem_resp, SCR1_MEM_RESP_NOTRDY);
    chk({tag, "_dmem_resp"}, dmem_resp, SCR1_MEM_RESP_NOTRDY);
    chk({tag, "_imem_rdata"}, imem_rdata, 32'h0);
    chk({tag, "_dmem_rdata"}, dmem_rdata, 32'h0);
    chk({tag, "_mem_req"}, mem_req, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    dmem_req = 1'b1;
    #1;
    chk("reset_mem_req_passthru", mem_req, 1'b1);
    chk("reset_dmem_ack", dmem_req_ack, 1'b0);
    dmem_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single imem read answered one cycle after the ack.
    iv = 1; iaddr = 32'h0048_0000; req_pct = 0; ack_pct = 100; dmin = 1; dmax = 1;
    use_next = 1; next_data = 32'h1234_5678;
    step();
    step();
    chk("single_imem_resp", imem_resp, SCR1_MEM_RESP_RDY_OK);
    chk("single_imem_rdata", imem_rdata, 32'h1234_5678);
    chk("single_dmem_resp", dmem_resp, SCR1_MEM_RESP_NOTRDY);
    drain();

    // Both ports busy with immediate acks: imem breaks through after LIMIT dmem grants.
    req_pct = 100; ack_pct = 100; dmin = 1; dmax = 1; glog = ""; log_en = 1;
    repeat (12) step();
    log_en = 0;
    total++;
    if (glog != "DDDDIDDDDI") begin
      bad++;
      $display("FAIL grant_order: got=%s expected=DDDDIDDDDI", glog);
    end
    drain();

    // Random traffic: stalled acks, variable latency, some error responses.
    req_pct = 60; ack_pct = 60; dmin = 1; dmax = 4; err_pct = 15;
    repeat (1500) step();
    drain();

    // Slow downstream keeps the ID FIFO full.
    req_pct = 100; ack_pct = 100; dmin = 5; dmax = 5; err_pct = 10;
    repeat (300) step();

    // Reset with requests outstanding, then a stale response after release.
    @(posedge clk);
    cyc++;
    #1;
    rst_n = 1'b0;
    iv = 0; dv = 0; imem_req = 0; dmem_req = 0; mem_req_ack = 0;
    mem_resp = SCR1_MEM_RESP_NOTRDY;
    exp_q.delete(); pend_q.delete();
    ost = 0; lock_v = 0; starve = 0; last_due = cyc;
    @(negedge clk);
    check_idle_outputs("midreset");
    @(posedge clk);
    cyc++;
    #1;
    rst_n = 1'b1;
    req_pct = 0; inject_late = 1;
    step();
    chk("late_imem_resp", imem_resp, SCR1_MEM_RESP_NOTRDY);
    chk("late_dmem_resp", dmem_resp, SCR1_MEM_RESP_NOTRDY);

    req_pct = 70; ack_pct = 70; dmin = 1; dmax = 6; err_pct = 15;
    repeat (400) step();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
